// File: rtl/simon_io_pkg.sv
// Shared constants and types for the Simon board I/O path.
// Button port address, random port address and debounce defaults.
package simon_io_pkg;

    localparam int NUM_BTN                 = 4;
    localparam int BTN_ADDR                = 1000;
    localparam int RAND_ADDR               = 2000;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

    typedef logic [NUM_BTN-1:0] btn_vec_t;

    // Counter width that can hold DEBOUNCE_CYCLES-1; a one-cycle filter still needs one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: two-flop synchroniser, consecutive-sample debounce counter and level flop.
// rise pulses for the single cycle following the edge on which level goes 0 -> 1.
module btn_debounce_cell
    import simon_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;
    logic             w_mismatch;
    logic             w_accept;

    assign w_mismatch = (r_sync1 != r_level);
    assign w_accept   = w_mismatch && (r_cnt == CNT_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= btn_raw;
            r_sync1 <= r_sync0;
            r_rise  <= w_accept && r_sync1;
            // Any sample agreeing with the current level restarts the qualification window.
            if (w_accept) begin
                r_level <= r_sync1;
                r_cnt   <= '0;
            end else if (w_mismatch) begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt   <= '0;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/simon_button_conditioner.sv
// Button front end for the CPU port at address 1000: per-button debounce plus press events.
// BTN_STICKY_EN defined: presses latch until rd_ack; undefined: one-cycle press pulses only.
module simon_button_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = simon_io_pkg::DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = simon_io_pkg::cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               rd_ack,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_event,
    output logic               btn_any
);

    import simon_io_pkg::*;

    logic [NUM_BTN-1:0] w_rise;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_cell
            btn_debounce_cell #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_cell (
                .clock   (clock),
                .reset   (reset),
                .btn_raw (btn_raw[gi]),
                .level   (btn_level[gi]),
                .rise    (w_rise[gi])
            );
        end
    endgenerate

`ifdef BTN_STICKY_EN
    logic [NUM_BTN-1:0] r_event;

    // r_event holds everything shown before this edge minus an acknowledged read;
    // OR-ing w_rise on the output side lets a press on the read edge survive the clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_event <= '0;
        end else if (rd_ack) begin
            r_event <= '0;
        end else begin
            r_event <= btn_event;
        end
    end

    assign btn_event = r_event | w_rise;
`else
    logic w_unused_ack;

    assign w_unused_ack = rd_ack;
    assign btn_event    = w_rise;
`endif

    assign btn_any = |btn_event;

endmodule

// File: tb/tb_simon_button_conditioner.sv
// Random and directed stimulus for simon_button_conditioner against a sample-window model.
module tb_simon_button_conditioner;
    import simon_io_pkg::*;

    localparam int D = 4;
`ifdef BTN_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic     clock = 1'b0;
    logic     reset;
    btn_vec_t btn_raw;
    logic     rd_ack;
    btn_vec_t btn_level;
    btn_vec_t btn_event;
    logic     btn_any;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clock = ~clock;

    simon_button_conditioner #(
        .NUM_BTN         (NUM_BTN),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .rd_ack    (rd_ack),
        .btn_level (btn_level),
        .btn_event (btn_event),
        .btn_any   (btn_any)
    );

    // Model: hist[k] is btn_raw sampled at the k-th edge since reset release.
    // The logic sees at edge k the raw value sampled at edge k-2. A level flips at edge e
    // when the D samples seen at edges e-D+1..e all disagree with it and it has not
    // flipped within that window.
    btn_vec_t hist[$];
    int       e = 0;
    int       last_flip[NUM_BTN];
    btn_vec_t m_level = '0;
    btn_vec_t m_event = '0;

    function automatic logic seen(input int k, input int i);
        if (k - 2 < 1) return 1'b0;
        return hist[k-2][i];
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist.delete();
            hist.push_back('0);
            e       = 0;
            m_level = '0;
            m_event = '0;
            for (int i = 0; i < NUM_BTN; i++) last_flip[i] = 0;
        end else begin : model_step
            btn_vec_t rise;
            bit       ok;
            rise = '0;
            e++;
            hist.push_back(btn_raw);
            for (int i = 0; i < NUM_BTN; i++) begin
                if (e - last_flip[i] >= D) begin
                    ok = 1'b1;
                    for (int j = e - D + 1; j <= e; j++)
                        if (seen(j, i) == m_level[i]) ok = 1'b0;
                    if (ok) begin
                        m_level[i]   = ~m_level[i];
                        last_flip[i] = e;
                        if (m_level[i]) rise[i] = 1'b1;
                    end
                end
            end
            if (STICKY) m_event = (rd_ack ? btn_vec_t'(0) : m_event) | rise;
            else        m_event = rise;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        n_vec++;
        if (btn_level !== m_level || btn_event !== m_event || btn_any !== (|m_event)) begin
            n_mis++;
            $display("FAIL model t=%0t level=%b want %b event=%b want %b any=%b want %b",
                     $time, btn_level, m_level, btn_event, m_event, btn_any, |m_event);
        end
    end

    // Literal expectation: DUT and model must both equal the hand-computed value.
    task automatic check(input string name, input btn_vec_t got, input btn_vec_t mdl,
                         input btn_vec_t exp);
        n_vec++;
        if (got !== exp || mdl !== exp) begin
            n_mis++;
            $display("FAIL %s t=%0t dut=%b model=%b want %b", name, $time, got, mdl, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic ack_pulse();
        rd_ack = 1'b1;
        step(1);
        rd_ack = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        rd_ack  = 1'b0;
        btn_raw = 4'b1111;
        step(2);
        check("reset_level", btn_level, m_level, 4'b0000);
        check("reset_event", btn_event, m_event, 4'b0000);
        check("reset_any", {3'b000, btn_any}, {3'b000, |m_event}, 4'b0000);

        // Held through reset release: qualifies at edge 6.
        reset = 1'b1;
        step(5);
        check("hold_e5_level", btn_level, m_level, 4'b0000);
        step(1);
        check("hold_e6_level", btn_level, m_level, 4'b1111);
        check("hold_e6_event", btn_event, m_event, 4'b1111);
        step(1);
        check("hold_e7_event", btn_event, m_event, STICKY ? 4'b1111 : 4'b0000);
        btn_raw = 4'b0000;
        step(10);
        check("release_level", btn_level, m_level, 4'b0000);
        ack_pulse();
        check("ack_clear", btn_event, m_event, 4'b0000);

        // Glitch rejection then full-length qualification on BTN2.
        btn_raw = 4'b0100;
        step(3);
        btn_raw = 4'b0000;
        step(10);
        check("glitch_level", btn_level, m_level, 4'b0000);
        check("glitch_event", btn_event, m_event, 4'b0000);
        btn_raw = 4'b0100;
        step(5);
        check("btn2_e5_level", btn_level, m_level, 4'b0000);
        step(1);
        check("btn2_e6_level", btn_level, m_level, 4'b0100);
        check("btn2_e6_event", btn_event, m_event, 4'b0100);
        btn_raw = 4'b0000;
        step(8);
        ack_pulse();

        // Short press of BTN0 survives until read.
        btn_raw = 4'b0001;
        step(8);
        btn_raw = 4'b0000;
        step(20);
        check("sticky_event", btn_event, m_event, STICKY ? 4'b0001 : 4'b0000);
        check("sticky_any", {3'b000, btn_any}, {3'b000, |m_event}, STICKY ? 4'b0001 : 4'b0000);
        ack_pulse();
        check("sticky_cleared", btn_event, m_event, 4'b0000);

        // rd_ack on the BTN3 press edge while BTN1 is latched.
        btn_raw = 4'b0010;
        step(8);
        btn_raw = 4'b0000;
        step(8);
        btn_raw = 4'b1000;
        step(5);
        rd_ack = 1'b1;
        step(1);
        rd_ack = 1'b0;
        check("setwins_event", btn_event, m_event, 4'b1000);
        btn_raw = 4'b0000;
        step(8);
        ack_pulse();

        // Simultaneous BTN1+BTN2 press then release.
        btn_raw = 4'b0110;
        step(5);
        check("simul_e5_event", btn_event, m_event, 4'b0000);
        step(1);
        check("simul_e6_level", btn_level, m_level, 4'b0110);
        check("simul_e6_event", btn_event, m_event, 4'b0110);
        btn_raw = 4'b0000;
        step(6);
        check("simul_rel_level", btn_level, m_level, 4'b0000);
        check("simul_rel_event", btn_event, m_event, STICKY ? 4'b0110 : 4'b0000);
        ack_pulse();

        // Reset mid-debounce discards the partial count.
        btn_raw = 4'b0001;
        step(3);
        reset = 1'b0;
        step(1);
        check("midrst_level", btn_level, m_level, 4'b0000);
        reset = 1'b1;
        step(5);
        check("midrst_e5_level", btn_level, m_level, 4'b0000);
        step(1);
        check("midrst_e6_level", btn_level, m_level, 4'b0001);
        check("midrst_e6_event", btn_event, m_event, 4'b0001);
        btn_raw = 4'b0000;
        step(8);
        ack_pulse();

        // Randomised phase: alternate calm and bouncy stretches, random reads, rare resets.
        for (int blk = 0; blk < 40; blk++) begin
            int hold_max;
            hold_max = (blk % 3 == 0) ? 2 : 12;
            for (int c = 0; c < 80; c++) begin
                if ($urandom_range(0, hold_max) == 0) btn_raw = btn_vec_t'($urandom_range(0, 15));
                rd_ack = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 799) == 0) begin
                    reset = 1'b0;
                    step(1);
                    reset = 1'b1;
                end else begin
                    step(1);
                end
            end
        end
        rd_ack = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
